pwm_dead_time: RTL and testbench

Per-channel dead-time insertion stage directly downstream of the PWM device. It consumes each channel's pwm_en/pwm_out pair and produces complementary high-side/low-side gate drives. The two drives never overlap, and a programmable dead interval separates them on every edge. Outputs go to the pad/IO mux in place of the raw PWM output.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_dead_time_channel.sv | 123 ++++++++++++
 rtl/pwm_dead_time.sv | 38 +++
 tb/tb_pwm_dead_time.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the PWM dead-time stage: per-channel FSM state encoding and dead-time floor.
package pwm_pkg;

  typedef enum logic [2:0] {
    OFF          = 3'd0,
    LOW_ON       = 3'd1,
    DEAD_TO_HIGH = 3'd2,
    HIGH_ON      = 3'd3,
    DEAD_TO_LOW  = 3'd4
  } dead_state_t;

  localparam int MIN_DEAD = 1;

  function automatic logic is_dead(input dead_state_t s);
    return (s == DEAD_TO_HIGH) || (s == DEAD_TO_LOW);
  endfunction

endpackage

// File: rtl/pwm_dead_time_channel.sv
// One channel: FSM + dead counter turning a raw PWM level into non-overlapping high/low drives.
// Outputs are registered decodes of next state; drive swaps take max(dead_time,1) cycles of both-off.
module pwm_dead_time_channel
  import pwm_pkg::*;
#(
  parameter int DEAD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DEAD_WIDTH-1:0] dead_time,
  input  logic                  pwm_en,
  input  logic                  pwm_in,
  output logic                  pwm_high,
  output logic                  pwm_low,
  output logic                  pwm_high_en,
  output logic                  pwm_low_en,
  output logic                  dead_active
);

  dead_state_t           state_q, state_d;
  logic [DEAD_WIDTH-1:0] cnt_q, cnt_d;
  logic                  from_off_q, from_off_d;
  logic                  high_q, high_d;
  logic                  low_q, low_d;
  logic                  out_en_q, out_en_d;
  logic                  dead_q, dead_d;
  logic [DEAD_WIDTH-1:0] dead_load;

  // Counter holds remaining cycles minus one, so a zero config still yields one dead cycle.
  assign dead_load = (dead_time < DEAD_WIDTH'(MIN_DEAD)) ? '0 : dead_time - DEAD_WIDTH'(MIN_DEAD);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    from_off_d = from_off_q;
    if (!pwm_en) begin
      state_d    = OFF;
      cnt_d      = '0;
      from_off_d = 1'b0;
    end else begin
      case (state_q)
        OFF: begin
          state_d    = pwm_in ? DEAD_TO_HIGH : DEAD_TO_LOW;
          cnt_d      = dead_load;
          from_off_d = 1'b1;
        end
        LOW_ON: if (pwm_in) begin
          state_d    = DEAD_TO_HIGH;
          cnt_d      = dead_load;
          from_off_d = 1'b0;
        end
        HIGH_ON: if (!pwm_in) begin
          state_d    = DEAD_TO_LOW;
          cnt_d      = dead_load;
          from_off_d = 1'b0;
        end
        // An abort returns to the previous drive unless nothing has been driven since enable.
        DEAD_TO_HIGH: begin
          if (!pwm_in) begin
            if (from_off_q) begin
              state_d = DEAD_TO_LOW;
              cnt_d   = dead_load;
            end else begin
              state_d = LOW_ON;
            end
          end else if (cnt_q == '0) begin
            state_d = HIGH_ON;
          end else begin
            cnt_d = cnt_q - DEAD_WIDTH'(1);
          end
        end
        DEAD_TO_LOW: begin
          if (pwm_in) begin
            if (from_off_q) begin
              state_d = DEAD_TO_HIGH;
              cnt_d   = dead_load;
            end else begin
              state_d = HIGH_ON;
            end
          end else if (cnt_q == '0) begin
            state_d = LOW_ON;
          end else begin
            cnt_d = cnt_q - DEAD_WIDTH'(1);
          end
        end
        default: state_d = OFF;
      endcase
    end
    high_d   = (state_d == HIGH_ON);
    low_d    = (state_d == LOW_ON);
    out_en_d = (state_d != OFF);
    dead_d   = is_dead(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      from_off_q <= 1'b0;
      high_q     <= 1'b0;
      low_q      <= 1'b0;
      out_en_q   <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      from_off_q <= from_off_d;
      high_q     <= high_d;
      low_q      <= low_d;
      out_en_q   <= out_en_d;
      dead_q     <= dead_d;
    end
  end

  assign pwm_high    = high_q;
  assign pwm_low     = low_q;
  assign pwm_high_en = out_en_q;
  assign pwm_low_en  = out_en_q;
  assign dead_active = dead_q;

  no_overlap_a: assert property (@(posedge clk) disable iff (!rst_n) !(high_q && low_q));

endmodule

// File: rtl/pwm_dead_time.sv
// Dead-time insertion for OUTPUTS PWM channels; fans the shared dead_time to independent channels.
// Drive drops one edge after a pwm_in change; the opposite drive rises max(deadTime,1) edges later.
module pwm_dead_time
  import pwm_pkg::*;
#(
  parameter int OUTPUTS    = 4,
  parameter int DEAD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEAD_WIDTH-1:0] deadTime,
  input  logic [OUTPUTS-1:0]    pwm_en,
  input  logic [OUTPUTS-1:0]    pwm_in,
  output logic [OUTPUTS-1:0]    pwm_high,
  output logic [OUTPUTS-1:0]    pwm_low,
  output logic [OUTPUTS-1:0]    pwm_high_en,
  output logic [OUTPUTS-1:0]    pwm_low_en,
  output logic [OUTPUTS-1:0]    deadActive
);

  for (genvar g = 0; g < OUTPUTS; g++) begin : g_ch
    pwm_dead_time_channel #(
      .DEAD_WIDTH(DEAD_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst),
      .dead_time  (deadTime),
      .pwm_en     (pwm_en[g]),
      .pwm_in     (pwm_in[g]),
      .pwm_high   (pwm_high[g]),
      .pwm_low    (pwm_low[g]),
      .pwm_high_en(pwm_high_en[g]),
      .pwm_low_en (pwm_low_en[g]),
      .dead_active(deadActive[g])
    );
  end

endmodule

// File: tb/tb_pwm_dead_time.sv
// Bench for pwm_dead_time: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a gap-timer model of the drive sides.
module tb_pwm_dead_time;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dead_time;
  logic [N-1:0]  en, pin;
  logic [N-1:0]  high, low, high_en, low_en, dead;

  always #5 clk = ~clk;

  pwm_dead_time #(.OUTPUTS(N), .DEAD_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .deadTime   (dead_time),
    .pwm_en     (en),
    .pwm_in     (pin),
    .pwm_high   (high),
    .pwm_low    (low),
    .pwm_high_en(high_en),
    .pwm_low_en (low_en),
    .deadActive (dead)
  );

  int checks = 0;
  int errors = 0;

  // Model per channel: side driven (0 none, 1 low, 2 high), side awaited in a gap,
  // side driven before the gap, and gap cycles remaining.
  int m_drive[N];
  int m_pend[N];
  int m_origin[N];
  int m_left[N];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_vec(input int kind);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       v[i] = (m_drive[i] == 2);
        1:       v[i] = (m_drive[i] == 1);
        2:       v[i] = (m_drive[i] != 0) || (m_pend[i] != 0);
        default: v[i] = (m_pend[i] != 0);
      endcase
    end
    return v;
  endfunction

  task automatic model_edge();
    int d, tgt;
    d = (dead_time == 0) ? 1 : int'(dead_time);
    for (int i = 0; i < N; i++) begin
      tgt = pin[i] ? 2 : 1;
      if (!rst || !en[i]) begin
        m_drive[i] = 0;
        m_pend[i]  = 0;
        m_origin[i] = 0;
        m_left[i]  = 0;
      end else if (m_pend[i] == 0) begin
        if (m_drive[i] != tgt) begin
          m_origin[i] = m_drive[i];
          m_drive[i]  = 0;
          m_pend[i]   = tgt;
          m_left[i]   = d;
        end
      end else if (tgt != m_pend[i]) begin
        if (m_origin[i] == 0) begin
          m_pend[i] = tgt;
          m_left[i] = d;
        end else begin
          m_drive[i] = m_origin[i];
          m_pend[i]  = 0;
        end
      end else begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          m_drive[i] = m_pend[i];
          m_pend[i]  = 0;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_drive[i] = 0; m_pend[i] = 0; m_origin[i] = 0; m_left[i] = 0;
    end
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("high", high, exp_vec(0));
      chk("low", low, exp_vec(1));
      chk("high_en", high_en, exp_vec(2));
      chk("low_en", low_en, exp_vec(2));
      chk("dead", dead, exp_vec(3));
      chk("overlap", high & low, '0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; en = '1; pin = '1; dead_time = 8'd3;
    step(3);
    chk("t1_rst_outs", high | low | high_en | low_en | dead, '0);
    rst = 1'b1;
    step(3);
    chk("t1_high_pre", high[0], 1'b0);
    chk("t1_dead_pre", dead[0], 1'b1);
    step(1);
    chk("t1_high_rise", high[0], 1'b1);
    chk("t1_low", low, '0);

    pin = '0; dead_time = 8'd5;
    step(12);
    chk("t2_all_low", low, 4'hF);
    pin[0] = 1'b1;
    step(1);
    chk("t2_low_fall", low[0], 1'b0);
    chk("t2_dead_in", dead[0], 1'b1);
    step(4);
    chk("t2_high_wait", high[0], 1'b0);
    chk("t2_dead_last", dead[0], 1'b1);
    step(1);
    chk("t2_high_rise", high[0], 1'b1);
    chk("t2_dead_out", dead[0], 1'b0);
    pin[0] = 1'b0;
    step(1);
    chk("t2_high_fall", high[0], 1'b0);
    step(4);
    chk("t2_low_wait", low[0], 1'b0);
    step(1);
    chk("t2_low_rise", low[0], 1'b1);

    dead_time = 8'd0;
    pin[1] = 1'b1;
    step(1);
    chk("t3_gap", {high[1], low[1], dead[1]}, 4'b0001);
    step(1);
    chk("t3_high", high[1], 1'b1);
    pin[1] = 1'b0;
    step(1);
    chk("t3_gap_back", {high[1], low[1]}, 4'b0000);
    step(1);
    chk("t3_low", low[1], 1'b1);

    dead_time = 8'd6;
    pin[0] = 1'b1;
    step(3);
    chk("t4_no_high", high[0], 1'b0);
    pin[0] = 1'b0;
    step(1);
    chk("t4_low_back", {high[0], low[0], dead[0]}, 4'b0010);

    dead_time = 8'd4;
    pin[2] = 1'b1;
    step(2);
    chk("t5_in_dead", dead[2], 1'b1);
    en[2] = 1'b0;
    step(1);
    chk("t5_off_dead", {high[2], low[2], high_en[2], low_en[2]}, 4'b0000);
    chk("t5_others", low & 4'b1011, 4'b1011);
    en[2] = 1'b1;
    step(8);
    chk("t5_high", high[2], 1'b1);
    en[2] = 1'b0;
    step(1);
    chk("t5_off_high", {high[2], low[2], high_en[2], dead[2]}, 4'b0000);
    en[2] = 1'b1;
    pin[2] = 1'b0;
    step(8);

    dead_time = 8'd8;
    pin[3] = 1'b1;
    step(3);
    dead_time = 8'd2;
    step(5);
    chk("t6_still_dead", {high[3], dead[3]}, 4'b0001);
    step(1);
    chk("t6_high", high[3], 1'b1);
    pin[3] = 1'b0;
    step(2);
    chk("t6_short_dead", {low[3], dead[3]}, 4'b0001);
    step(1);
    chk("t6_low", low[3], 1'b1);

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) pin[i] = ~pin[i];
        en[i] = ($urandom_range(0, 59) != 0);
      end
      if ($urandom_range(0, 49) == 0) dead_time = DW'($urandom_range(0, 7));
      step(1);
    end

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
